// File: rtl/mdl_op_seq.sv
// mdl_op_seq: steps the NTT / INTT / pointwise-multiply engines through a
// fixed per-mode sequence, one start pulse per step, advancing on the
// matching done pulse. Busy, completion and sticky error status go back to
// the control register block.
// Optional build macro SEQ_TIMEOUT_EN adds a per-step watchdog that aborts a
// step stuck in WAIT for TO_CYCLES cycles and reports error code 11.
module mdl_op_seq #(
    parameter int          TO_WIDTH  = 16,
    parameter int unsigned TO_CYCLES = 16'hFFFF
) (
    input  logic       iSYS_CLK,
    input  logic       iSYS_RST,
    input  logic [2:0] iCTL_MODE,
    output logic       oNTT_START,
    input  logic       iNTT_DONE,
    output logic       oINTT_START,
    input  logic       iINTT_DONE,
    output logic       oPWM_START,
    input  logic       iPWM_DONE,
    output logic       oBANK_SEL,
    output logic       oBUSY,
    output logic       oDONE,
    output logic [1:0] oERR,
    output logic [1:0] oSTEP
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

    localparam logic [1:0] ENG_NTT  = 2'd0;
    localparam logic [1:0] ENG_INTT = 2'd1;
    localparam logic [1:0] ENG_PWM  = 2'd2;

    localparam logic [2:0] MODE_NONE    = 3'b000;
    localparam logic [2:0] MODE_FULL    = 3'b100;
    localparam logic [2:0] MODE_NTT_B   = 3'b101;
    localparam logic [2:0] MODE_ILLEGAL = 3'b110;
    localparam logic [2:0] MODE_ABORT   = 3'b111;

    // Engine used by a given step of a given mode.
    function automatic logic [1:0] step_eng(input logic [2:0] mode, input logic [1:0] step);
        logic [1:0] eng;
        eng = ENG_NTT;
        case (mode)
            3'b010:    eng = ENG_INTT;
            3'b011:    eng = ENG_PWM;
            MODE_FULL: begin
                case (step)
                    2'd2:    eng = ENG_PWM;
                    2'd3:    eng = ENG_INTT;
                    default: eng = ENG_NTT;
                endcase
            end
            default:   eng = ENG_NTT;
        endcase
        return eng;
    endfunction

    // Operand bank for an NTT step: B for mode 101 and for step 1 of the full poly-mul.
    function automatic logic step_bank(input logic [2:0] mode, input logic [1:0] step);
        return (mode == MODE_NTT_B) || ((mode == MODE_FULL) && (step == 2'd1));
    endfunction

    // Index of the final step of a mode; only the full poly-mul has more than one.
    function automatic logic [1:0] last_step(input logic [2:0] mode);
        return (mode == MODE_FULL) ? 2'd3 : 2'd0;
    endfunction

    state_t     state_q, state_d;
    logic [2:0] mode_q, mode_d;
    logic [1:0] step_q, step_d;
    logic [1:0] err_q, err_d;

    logic       cmd_legal;
    logic       cmd_abort;
    logic       eng_done;
    logic [1:0] cur_eng;
    logic [1:0] nxt_eng;

    logic       ntt_start_d, intt_start_d, pwm_start_d;
    logic       bank_d, busy_d, done_d;

    assign cmd_legal = (iCTL_MODE != MODE_NONE) && (iCTL_MODE != MODE_ILLEGAL) &&
                       (iCTL_MODE != MODE_ABORT);
    assign cmd_abort = (iCTL_MODE == MODE_ABORT);
    assign cur_eng   = step_eng(mode_q, step_q);
    assign eng_done  = ((cur_eng == ENG_NTT)  && iNTT_DONE)  ||
                       ((cur_eng == ENG_INTT) && iINTT_DONE) ||
                       ((cur_eng == ENG_PWM)  && iPWM_DONE);

`ifdef SEQ_TIMEOUT_EN
    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TO_CYCLES - 1);

    logic [TO_WIDTH-1:0] wdog_q;
    logic                wdog_expired;

    assign wdog_expired = (wdog_q == TO_LAST);

    // Watchdog: counts WAIT cycles of the current step, cleared everywhere else.
    always_ff @(posedge iSYS_CLK) begin
        if (iSYS_RST)
            wdog_q <= '0;
        else if (state_q == ST_WAIT)
            wdog_q <= wdog_q + 1'b1;
        else
            wdog_q <= '0;
    end
`endif

    // State register plus registered outputs.
    always_ff @(posedge iSYS_CLK) begin
        if (iSYS_RST) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_NONE;
            step_q      <= 2'd0;
            err_q       <= 2'b00;
            oNTT_START  <= 1'b0;
            oINTT_START <= 1'b0;
            oPWM_START  <= 1'b0;
            oBANK_SEL   <= 1'b0;
            oBUSY       <= 1'b0;
            oDONE       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            step_q      <= step_d;
            err_q       <= err_d;
            oNTT_START  <= ntt_start_d;
            oINTT_START <= intt_start_d;
            oPWM_START  <= pwm_start_d;
            oBANK_SEL   <= bank_d;
            oBUSY       <= busy_d;
            oDONE       <= done_d;
        end
    end

    // Next-state: command decode, step advance, abort and error tracking.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        step_d  = step_q;
        err_d   = err_q;
        if (state_q == ST_IDLE) begin
            if (cmd_legal) begin
                mode_d  = iCTL_MODE;
                step_d  = 2'd0;
                err_d   = 2'b00;
                state_d = ST_ISSUE;
            end else if (iCTL_MODE == MODE_ILLEGAL) begin
                err_d = 2'b01;
            end
        end else if (cmd_abort) begin
            // Abort beats a same-cycle done; error status is left alone.
            state_d = ST_IDLE;
        end else begin
            if (iCTL_MODE != MODE_NONE)
                err_d = 2'b10;
            case (state_q)
                ST_ISSUE: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (eng_done) begin
                        if (step_q == last_step(mode_q)) begin
                            state_d = ST_DONE;
                        end else begin
                            step_d  = step_q + 2'd1;
                            state_d = ST_ISSUE;
                        end
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (wdog_expired) begin
                        err_d   = 2'b11;
                        state_d = ST_IDLE;
                    end
`endif
                end
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Output decode from the upcoming state so every output leaves a flop.
    always_comb begin
        nxt_eng      = step_eng(mode_d, step_d);
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);
        ntt_start_d  = (state_d == ST_ISSUE) && (nxt_eng == ENG_NTT);
        intt_start_d = (state_d == ST_ISSUE) && (nxt_eng == ENG_INTT);
        pwm_start_d  = (state_d == ST_ISSUE) && (nxt_eng == ENG_PWM);
        bank_d       = ((state_d == ST_ISSUE) || (state_d == ST_WAIT)) &&
                       (nxt_eng == ENG_NTT) && step_bank(mode_d, step_d);
    end

    assign oERR  = err_q;
    assign oSTEP = step_q;

endmodule

// File: tb/tb_mdl_op_seq.sv
// Bench for mdl_op_seq: engine responders, an event scoreboard of start and
// done pulses, and directed command scenarios.
module tb_mdl_op_seq;

`ifdef SEQ_TIMEOUT_EN
    localparam int TOC = 16;
`else
    localparam int TOC = 16'hFFFF;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] mode = 3'b000;
    logic       ntt_done = 1'b0, intt_done = 1'b0, pwm_done = 1'b0;
    logic       ntt_start, intt_start, pwm_start, bank_sel, busy, done;
    logic [1:0] err, step;

    mdl_op_seq #(.TO_WIDTH(16), .TO_CYCLES(TOC)) dut (
        .iSYS_CLK   (clk),
        .iSYS_RST   (rst),
        .iCTL_MODE  (mode),
        .oNTT_START (ntt_start),
        .iNTT_DONE  (ntt_done),
        .oINTT_START(intt_start),
        .iINTT_DONE (intt_done),
        .oPWM_START (pwm_start),
        .iPWM_DONE  (pwm_done),
        .oBANK_SEL  (bank_sel),
        .oBUSY      (busy),
        .oDONE      (done),
        .oERR       (err),
        .oSTEP      (step)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int q[$];
    int cyc = 0;
    int done_cyc = -10;
    int done_seen = 0;
    int starts_seen = 0;
    int lat = 3;
    int resp_left = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic cmd(input logic [2:0] m);
        @(posedge clk);
        #1 mode = m;
        @(posedge clk);
        #1 mode = 3'b000;
    endtask

    task automatic wait_done(input int n);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (done_seen > n) break;
        end
        chk("wait_done", done_seen, n + 1);
    endtask

    task automatic push_full();
        q.push_back(8);   // NTT bank A step 0
        q.push_back(13);  // NTT bank B step 1
        q.push_back(26);  // PWM step 2
        q.push_back(19);  // INTT step 3
        q.push_back(35);  // DONE at step 3
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Event monitor and engine responder. Event code = kind*8 + bank*4 + step,
    // kind 1 NTT, 2 INTT, 3 PWM, 4 sequence done.
    initial begin
        int cnt;
        int eng;
        int code;
        cnt = 0;
        eng = 0;
        forever begin
            @(negedge clk);
            ntt_done  = 1'b0;
            intt_done = 1'b0;
            pwm_done  = 1'b0;
            if (!rst) begin
                code = 0;
                if (ntt_start)       code = 8;
                else if (intt_start) code = 16;
                else if (pwm_start)  code = 24;
                else if (done)       code = 32;
                if (code != 0) begin
                    code = code + int'(bank_sel) * 4 + int'(step);
                    if (q.size() == 0) chk("sb_extra", code, 0);
                    else chk("sb_evt", code, q.pop_front());
                end
                if (done) begin
                    done_seen++;
                    chk("done_lat", cyc, done_cyc + 1);
                end
                if (ntt_start || intt_start || pwm_start) begin
                    starts_seen++;
                    if (resp_left > 0) begin
                        resp_left--;
                        cnt = lat;
                        eng = code >> 3;
                    end
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        case (eng)
                            1:       ntt_done  = 1'b1;
                            2:       intt_done = 1'b1;
                            default: pwm_done  = 1'b1;
                        endcase
                        done_cyc = cyc;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int s;
        int low;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_step", step, 0);
        chk("rst_bank", bank_sel, 0);
        chk("rst_starts", {ntt_start, intt_start, pwm_start}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single NTT on bank A, engine answers 5 cycles after start
        lat = 5; resp_left = 1;
        q.push_back(8); q.push_back(32);
        n = done_seen;
        cmd(3'b001);
        tick();
        chk("t1_busy", busy, 1);
        chk("t1_start", ntt_start, 1);
        wait_done(n);
        tick();
        chk("t1_busy_fall", busy, 0);
        chk("t1_err", err, 0);

        // Full poly-mul, 3-cycle engines
        lat = 3; resp_left = 4;
        push_full();
        n = done_seen;
        cmd(3'b100);
        wait_done(n);
        tick();
        chk("t2_busy_fall", busy, 0);
        chk("t2_step", step, 3);
        chk("t2_err", err, 0);

        // Command while busy is dropped, sequence completes
        resp_left = 4;
        push_full();
        n = done_seen;
        cmd(3'b100);
        repeat (4) @(posedge clk);
        cmd(3'b011);
        tick();
        chk("t3_err_busy", err, 2);
        wait_done(n);
        tick();
        chk("t3_err_hold", err, 2);
        chk("t3_busy_fall", busy, 0);

        // Illegal mode in IDLE
        cmd(3'b110);
        tick();
        chk("t4_err_ill", err, 1);
        chk("t4_busy", busy, 0);
        repeat (3) tick();
        chk("t4_busy_later", busy, 0);

        // Abort during WAIT of step 2 (PWM never answers)
        resp_left = 2;
        q.push_back(8); q.push_back(13); q.push_back(26);
        s = starts_seen;
        n = done_seen;
        cmd(3'b100);
        tick();
        chk("t5_err_clr", err, 0);
        for (int i = 0; i < 100; i++) begin
            if (starts_seen >= s + 3) break;
            tick();
        end
        chk("t5_wait_pwm", starts_seen, s + 3);
        repeat (3) @(posedge clk);
        cmd(3'b111);
        tick();
        chk("t5_abort_busy", busy, 0);
        s = starts_seen;
        repeat (20) tick();
        chk("t5_no_start", starts_seen, s);
        chk("t5_no_done", done_seen, n);
        chk("t5_err", err, 0);

        // Step with no engine answer
        resp_left = 0;
        q.push_back(8);
        cmd(3'b001);
        tick();
        chk("t6_busy", busy, 1);
`ifdef SEQ_TIMEOUT_EN
        repeat (16) tick();
        chk("t6_busy_last_wait", busy, 1);
        tick();
        chk("t6_to_busy", busy, 0);
        chk("t6_to_err", err, 3);
`else
        low = 0;
        repeat (1000) begin
            tick();
            if (!busy) low++;
        end
        chk("t6_hold", low, 0);
        cmd(3'b111);
        tick();
        chk("t6_abort_busy", busy, 0);
        chk("t6_err", err, 0);
`endif

        repeat (5) tick();
        chk("sb_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
